proc_io_sched: RTL



---
 rtl/proc_io_pkg.sv | 16 +
 rtl/proc_io_slot.sv | 44 ++++
 rtl/proc_io_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/proc_io_pkg.sv
// Shared types and constants for the proc_fx I/O scheduler.
package proc_io_pkg;

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    localparam int unsigned STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/proc_io_slot.sv
// One-entry holding register with valid/ready and an overrun/underrun event.
module proc_io_slot #(
    parameter int unsigned W = 31
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         rd_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         event_o
);

    logic [W-1:0] data_q, data_d;
    logic         full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (rd_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    // Overwrite of a full entry not drained this cycle, or a read of an empty entry.
    assign event_o = (load_i & full_q & ~rd_i) | (rd_i & ~full_q);
    assign data_o  = data_q;
    assign full_o  = full_q;

endmodule

// File: rtl/proc_io_sched.sv
// I/O scheduler for proc_fx: buffered stream channels, start sequencing, error flags.
// Optional event counters enabled with `define PROC_IO_SCHED_STATS_EN.
module proc_io_sched
    import proc_io_pkg::*;
#(
    parameter int unsigned NUBITS = 31,
    parameter int unsigned NUIOIN = 2,
    parameter int unsigned NUIOOU = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUIOIN*NUBITS-1:0] s_data,
    input  logic [NUIOIN-1:0]        s_valid,
    output logic [NUIOIN-1:0]        s_ready,
    output logic [NUIOOU*NUBITS-1:0] m_data,
    output logic [NUIOOU-1:0]        m_valid,
    input  logic [NUIOOU-1:0]        m_ready,
    input  logic [NUIOIN-1:0]        proc_req_in,
    output logic [NUBITS-1:0]        proc_io_in,
    input  logic [NUIOOU-1:0]        proc_out_en,
    input  logic [NUBITS-1:0]        proc_io_out,
    output logic                     proc_rst,
    output logic [1:0]               state,
`ifdef PROC_IO_SCHED_STATS_EN
    output logic [STAT_W-1:0]        underrun_cnt,
    output logic [STAT_W-1:0]        overrun_cnt,
`endif
    output logic                     underrun,
    output logic                     overrun
);

    state_e state_q, state_d;
    logic   run;

    logic [NUIOIN-1:0]        in_full, in_evt;
    logic [NUIOIN*NUBITS-1:0] in_regs;
    logic [NUIOOU-1:0]        out_full, out_evt;
    logic                     underrun_q, underrun_d;
    logic                     overrun_q, overrun_d;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        proc_io_slot #(.W(NUBITS)) u_slot (
            .clk     (clk),
            .rst_n_i (rst),
            .load_i  (s_valid[k] & ~in_full[k]),
            .data_i  (s_data[k*NUBITS +: NUBITS]),
            .rd_i    (proc_req_in[k] & run),
            .data_o  (in_regs[k*NUBITS +: NUBITS]),
            .full_o  (in_full[k]),
            .event_o (in_evt[k])
        );
    end

    for (genvar j = 0; j < NUIOOU; j++) begin : g_out
        proc_io_slot #(.W(NUBITS)) u_slot (
            .clk     (clk),
            .rst_n_i (rst),
            .load_i  (proc_out_en[j] & run),
            .data_i  (proc_io_out),
            .rd_i    (m_ready[j] & out_full[j]),
            .data_o  (m_data[j*NUBITS +: NUBITS]),
            .full_o  (out_full[j]),
            .event_o (out_evt[j])
        );
    end

    assign s_ready = ~in_full;
    assign m_valid = out_full;

    // Descending scan so the lowest set strobe wins; no strobe selects channel 0.
    always_comb begin
        proc_io_in = in_regs[NUBITS-1:0];
        for (int unsigned i = NUIOIN; i > 0; i--) begin
            if (proc_req_in[i-1]) proc_io_in = in_regs[(i-1)*NUBITS +: NUBITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_HOLD;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HOLD:  if (enable) state_d = S_PRIME;
            S_PRIME: begin
                if (!enable)        state_d = S_HOLD;
                else if (&in_full)  state_d = S_RUN;
            end
            S_RUN:   if (!enable) state_d = S_HOLD;
            default: state_d = S_HOLD;
        endcase
    end

    always_comb begin
        run        = (state_q == S_RUN);
        proc_rst   = ~run;
        state      = state_q;
        underrun_d = underrun_q | (|in_evt);
        overrun_d  = overrun_q | (|out_evt);
    end

    assign underrun = underrun_q;
    assign overrun  = overrun_q;

`ifdef PROC_IO_SCHED_STATS_EN
    logic [STAT_W-1:0] underrun_cnt_q, overrun_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            underrun_cnt_q <= '0;
            overrun_cnt_q  <= '0;
        end else begin
            if (|in_evt)  underrun_cnt_q <= sat_inc(underrun_cnt_q);
            if (|out_evt) overrun_cnt_q  <= sat_inc(overrun_cnt_q);
        end
    end

    assign underrun_cnt = underrun_cnt_q;
    assign overrun_cnt  = overrun_cnt_q;
`endif

endmodule
